// File: rtl/cpu_pipe.sv
// cpu_pipe: two-stage (fetch / decode-execute-writeback) core, 16-bit instructions, 8 x DWIDTH registers.
// Define CPU_PIPE_EXTIMM_EN to take operand B from the next instruction word when bmode=10, rb=0.
module cpu_pipe #(
    parameter int DWIDTH     = 16,
    parameter int IADDRWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [IADDRWIDTH-1:0] iaddr,
    output logic                  ireq,
    input  logic [15:0]           idata,
    input  logic                  ivalid,
    output logic                  wb_valid,
    output logic [2:0]            wb_addr,
    output logic [DWIDTH-1:0]     wb_data
);
    localparam int SHW = $clog2(DWIDTH);

    typedef struct packed {
        logic [15:0]           ir;
        logic [IADDRWIDTH-1:0] pc;
        logic                  valid;
    } s2_t;

    logic [IADDRWIDTH-1:0] pc;
    s2_t                   s2;
    logic [DWIDTH-1:0]     rf [8];

    logic [3:0] op;
    logic [2:0] ra, rd, rb;
    logic [1:0] bmode;

    assign op    = s2.ir[15:12];
    assign ra    = s2.ir[11:9];
    assign rd    = s2.ir[7:5];
    assign bmode = s2.ir[4:3];
    assign rb    = s2.ir[2:0];

    assign iaddr = pc;
    assign ireq  = !rst;

    logic is_alu, is_br;
    assign is_alu = s2.valid && (op <= 4'hB);
    assign is_br  = s2.valid && (op[3:1] == 3'b110);

    logic              ext_op, stall;
    logic [DWIDTH-1:0] ext_b;
`ifdef CPU_PIPE_EXTIMM_EN
    // The word following an ext-imm op is its B operand; hold S2 until that fetch returns.
    assign ext_op = is_alu && (bmode == 2'b10) && (rb == 3'd0);
    assign stall  = ext_op && !ivalid;
    assign ext_b  = DWIDTH'($signed(idata));
`else
    assign ext_op = 1'b0;
    assign stall  = 1'b0;
    assign ext_b  = '0;
`endif

    logic [DWIDTH-1:0] a, b, res;
    logic signed [DWIDTH-1:0] asr_v;
    logic [SHW-1:0]    shamt;
    logic              b_big;

    assign a = rf[ra];

    always_comb begin
        b = DWIDTH'($signed(s2.ir[3:0]));
        if (bmode == 2'b10)
            b = (rb != 3'd0) ? rf[rb] : ext_b;
    end

    // Out-of-range shift amounts are caught before truncating to SHW bits.
    assign b_big = 72'(b) >= 72'(DWIDTH);
    assign shamt = b[SHW-1:0];
    assign asr_v = $signed(a) >>> shamt;

    always_comb begin
        res = '0;
        case (op)
            4'h0:    res = a + b;
            4'h1:    res = a - b;
            4'h2:    res = a & b;
            4'h3:    res = a | b;
            4'h4:    res = a ^ b;
            4'h5:    res = b_big ? '0 : (a << shamt);
            4'h6:    res = b_big ? '0 : (a >> shamt);
            4'h7:    res = b_big ? {DWIDTH{a[DWIDTH-1]}} : asr_v;
            4'h8:    res = DWIDTH'(a == b);
            4'h9:    res = DWIDTH'(a < b);
            4'hA:    res = DWIDTH'(a <= b);
            4'hB:    res = DWIDTH'($signed(a) < $signed(b));
            default: res = '0;
        endcase
    end

    logic                  retire, taken;
    logic [IADDRWIDTH-1:0] target;

    assign retire = is_alu && (bmode != 2'b11) && !stall;
    assign taken  = is_br && ((a == '0) ^ op[0]);
    assign target = s2.pc + IADDRWIDTH'(1) + IADDRWIDTH'($signed(s2.ir[8:0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            s2       <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            wb_valid <= retire;
            if (retire) begin
                rf[rd]  <= res;
                wb_addr <= rd;
                wb_data <= res;
            end
            // Redirect beats fetch advance; the word fetched alongside a taken branch is dropped.
            if (taken) begin
                pc       <= target;
                s2.valid <= 1'b0;
            end else if (stall) begin
                pc <= pc;
            end else if (ext_op) begin
                pc       <= pc + IADDRWIDTH'(1);
                s2.valid <= 1'b0;
            end else if (ivalid) begin
                pc <= pc + IADDRWIDTH'(1);
                s2 <= '{ir: idata, pc: pc, valid: 1'b1};
            end else begin
                s2.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_pipe.sv
// Scoreboard bench for cpu_pipe: expected writebacks queued per scenario, compared after the run.
module tb_cpu_pipe;
`ifdef CPU_PIPE_EXTIMM_EN
    localparam int DW = 32;
`else
    localparam int DW = 16;
`endif
    localparam logic [DW-1:0] ONES = '1;

    typedef struct packed {
        logic [2:0]    a;
        logic [DW-1:0] d;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ivalid = 1'b0;
    logic          ireq, wb_valid;
    logic [15:0]   iaddr, idata;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic [15:0]   mem [256];
    int            checks = 0;
    int            errors = 0;
    wb_t           exp_q[$];
    wb_t           obs_q[$];

    cpu_pipe #(.DWIDTH(DW), .IADDRWIDTH(16)) dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .ireq(ireq), .idata(idata),
        .ivalid(ivalid), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;
    assign idata = mem[iaddr[7:0]];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (wb_valid === 1'b1) obs_q.push_back('{wb_addr, wb_data});
    endtask

    task automatic load_clear();
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ivalid = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic push(input int a, input logic [63:0] d);
        wb_t e;
        e.a = 3'(a);
        e.d = DW'(d);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        load_clear();
        rst = 1'b1;
        step();
        step();
        checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL rst_ireq got %b want 0", ireq); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
        checks++; if (wb_addr !== 3'd0) begin errors++; $display("FAIL rst_wb_addr got %0d want 0", wb_addr); end
        checks++; if (wb_data !== '0) begin errors++; $display("FAIL rst_wb_data got %h want 0", wb_data); end
        checks++; if (iaddr !== 16'h0) begin errors++; $display("FAIL rst_iaddr got %h want 0", iaddr); end
        rst = 1'b0;
        #1;
        checks++; if (ireq !== 1'b1) begin errors++; $display("FAIL rel_ireq got %b want 1", ireq); end
        checks++; if (iaddr !== 16'h0) begin errors++; $display("FAIL rel_iaddr got %h want 0", iaddr); end
    endtask

    task automatic test_add();
        wb_t o, e;
        load_clear();
        mem[0] = 16'h0025;
        do_reset();
        ivalid = 1'b1;
        push(1, 5);
        step();
        step();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_latency got %b want 1", wb_valid); end
        repeat (2) step();
        ivalid = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL add_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL add_wb got r%0d=%h want r%0d=%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_alu();
        wb_t o, e;
        load_clear();
        mem[0]  = 16'h0025;  // r1 = r0 + 5
        mem[1]  = 16'h124F;  // r2 = r1 - (-1)
        mem[2]  = 16'h006F;  // r3 = r0 + (-1)
        mem[3]  = 16'h0681;  // r4 = r3 + 1 (wraps)
        mem[4]  = 16'h42B2;  // r5 = r1 ^ r2
        mem[5]  = 16'h52C4;  // r6 = r1 << 4
        mem[6]  = 16'h66F6;  // r7 = r3 >> r6 (over-range)
        mem[7]  = 16'h76F6;  // r7 = r3 >>> r6 (over-range)
        mem[8]  = 16'hB6B1;  // r5 = r3 <s r1
        mem[9]  = 16'h96B1;  // r5 = r3 <u r1
        mem[10] = 16'h02B8;  // bmode 11: no writeback
        mem[11] = 16'h82A5;  // r5 = r1 == 5
        mem[12] = 16'hA2B1;  // r5 = r1 <=u r1
        mem[13] = 16'h24A7;  // r5 = r2 & 7
        do_reset();
        ivalid = 1'b1;
        push(1, 5); push(2, 6); push(3, ONES); push(4, 0); push(5, 3); push(6, 80);
        push(7, 0); push(7, ONES); push(5, 1); push(5, 0); push(5, 1); push(5, 1); push(5, 6);
        repeat (17) step();
        ivalid = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL alu_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL alu_wb got r%0d=%h want r%0d=%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_branch();
        wb_t o, e;
        load_clear();
        mem[4]  = 16'hC003;  // beq r0 -> 8
        mem[5]  = 16'h0025;  // squashed
        mem[8]  = 16'h0047;  // r2 = 7
        mem[9]  = 16'hD003;  // bnz r0: not taken
        mem[10] = 16'h0061;  // r3 = 1
        do_reset();
        ivalid = 1'b1;
        push(2, 7); push(3, 1);
        repeat (5) step();
        checks++; if (iaddr !== 16'd5) begin errors++; $display("FAIL br_pre got %h want 5", iaddr); end
        step();
        checks++; if (iaddr !== 16'd8) begin errors++; $display("FAIL br_target got %h want 8", iaddr); end
        repeat (3) step();
        checks++; if (iaddr !== 16'd11) begin errors++; $display("FAIL br_nt_penalty got %h want 11", iaddr); end
        repeat (3) step();
        ivalid = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL br_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL br_wb got r%0d=%h want r%0d=%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_wrap();
        wb_t o, e;
        load_clear();
        mem[0]   = 16'hC1FE;  // beq r0, -2 -> 0xFFFF
        mem[255] = 16'h0083;  // r4 = 3
        do_reset();
        ivalid = 1'b1;
        push(4, 3);
        step();
        step();
        checks++; if (iaddr !== 16'hFFFF) begin errors++; $display("FAIL wrap_target got %h want ffff", iaddr); end
        step();
        checks++; if (iaddr !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h want 0", iaddr); end
        ivalid = 1'b0;
        repeat (3) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL wrap_wb got r%0d=%h want r%0d=%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_stall();
        wb_t o, e;
        load_clear();
        mem[0] = 16'h0025;
        do_reset();
        push(1, 5);
        repeat (3) begin
            step();
            checks++; if (iaddr !== 16'h0) begin errors++; $display("FAIL stall_iaddr got %h want 0", iaddr); end
        end
        ivalid = 1'b1;
        step();
        step();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_retire got %b want 1", wb_valid); end
        ivalid = 1'b0;
        repeat (2) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL stall_wb got r%0d=%h want r%0d=%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_branch_wait();
        wb_t o, e;
        load_clear();
        mem[0] = 16'hC003;  // beq r0 -> 4
        mem[4] = 16'h0025;
        do_reset();
        ivalid = 1'b1;
        push(1, 5);
        step();
        ivalid = 1'b0;
        step();
        checks++; if (iaddr !== 16'd4) begin errors++; $display("FAIL brwait_target got %h want 4", iaddr); end
        ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        repeat (2) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL brwait_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL brwait_wb got r%0d=%h want r%0d=%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_extimm();
        wb_t o, e;
        load_clear();
        mem[0] = 16'h3070;  // r3 = r0 | B (bmode 10, rb 0)
        mem[1] = 16'h8001;
        mem[2] = 16'h0025;
        do_reset();
`ifdef CPU_PIPE_EXTIMM_EN
        push(3, 32'hFFFF8001); push(1, 5);
`else
        push(3, 0); push(0, 0); push(1, 5);
`endif
        ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        step();
        checks++; if (iaddr !== 16'd1) begin errors++; $display("FAIL ext_hold1 got %h want 1", iaddr); end
        step();
        checks++; if (iaddr !== 16'd1) begin errors++; $display("FAIL ext_hold2 got %h want 1", iaddr); end
        ivalid = 1'b1;
        step();
        checks++; if (iaddr !== 16'd2) begin errors++; $display("FAIL ext_next_pc got %h want 2", iaddr); end
        repeat (2) step();
        ivalid = 1'b0;
        step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ext_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL ext_wb got r%0d=%h want r%0d=%h", o.a, o.d, e.a, e.d); end
        end
    endtask

    task automatic test_rst_mid();
        load_clear();
        mem[0] = 16'h3070;
        mem[1] = 16'h8001;
        do_reset();
        ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_wb got %b want 0", wb_valid); end
        checks++; if (iaddr !== 16'h0) begin errors++; $display("FAIL rstmid_pc got %h want 0", iaddr); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (ireq !== 1'b1 || iaddr !== 16'h0) begin errors++; $display("FAIL rstmid_restart got ireq=%b iaddr=%h want 1/0", ireq, iaddr); end
        repeat (2) step();
        checks++; if (iaddr !== 16'h0) begin errors++; $display("FAIL rstmid_idle got %h want 0", iaddr); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_count got %0d want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_branch();
        test_wrap();
        test_stall();
        test_branch_wait();
        test_extimm();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_pipe.md
CPU_PIPE -- requirements
Module: cpu_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, register and ALU data width (legal 16..64).
REQ-002 SHALL have parameter IADDRWIDTH, default 16, instruction address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port iaddr  output  IADDRWIDTH  instruction fetch address.
REQ-006 SHALL have port ireq  output  1  fetch request; iaddr is valid while ireq is high.
REQ-007 SHALL have port idata  input  16  instruction word, sampled only when ireq and ivalid are both high.
REQ-008 SHALL have port ivalid  input  1  fetch completes this cycle; low means wait state.
REQ-009 SHALL have port wb_valid  output  1  registered pulse, one register write retired last cycle.
REQ-010 SHALL have port wb_addr  output  3  register written.
REQ-011 SHALL have port wb_data  output  DWIDTH  value written.

Function
REQ-012 SHALL be a 2-stage pipeline: S1 fetch (pc), S2 decode/execute/writeback (ir, ir_pc, ir_valid), with an internal 8 x DWIDTH register file (combinational read, write on clk edge).
REQ-013 SHALL decode ir as op[15:12], ra[11:9], rd[7:5], bmode[4:3], rb[2:0]; bit 8 is reserved for ALU ops.
REQ-014 SHALL drive ireq=1 every non-reset cycle, holding iaddr stable while ivalid=0; on ivalid=1, pc advances by 1 and S2 loads {idata, pc, valid=1}; on ivalid=0, S2 loads a bubble (ir_valid=0).
REQ-015 SHALL form the ALU B operand as follows: bmode 0x -> ir[3:0] sign-extended to DWIDTH; bmode 10, rb!=0 -> reg[rb]; bmode 10, rb==0 -> extended immediate (REQ-021); bmode 11 -> no-op, no writeback.
REQ-016 SHALL implement these ops, writing reg[rd]: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 lsr, 7 asr (signed), 8 eq, 9 unsigned lt, A unsigned le, B signed lt; compare ops yield 1/0; arithmetic wraps modulo 2^DWIDTH; shift amounts >= DWIDTH yield 0 (shl/lsr) or sign fill (asr).
REQ-017 SHALL treat op 111x and bubbles as no-ops: no writeback, no branch.
REQ-018 SHALL implement branch op 110x as follows: target = ir_pc + 1 + sign-extended ir[8:0]; op 1100 is taken when reg[ra]==0; op 1101 is taken when reg[ra]!=0.
REQ-019 SHALL, on a taken branch, load pc with target at the same edge and squash the word fetched that cycle (S2 bubble next cycle), giving a 1-cycle branch penalty.
REQ-020 SHALL, on a not-taken branch, incur no penalty.
REQ-021 SHALL handle the extended immediate as follows: S2 stalls (ir held, no writeback) until the following fetch returns with ivalid=1; that word, sign-extended, is operand B; it never enters S2 as an instruction; retire occurs in the cycle it arrives.
REQ-022 SHALL ensure that a back-to-back dependent instruction reads the value written by the previous instruction (write edge precedes read).
REQ-023 SHALL let pc wrap from 2^IADDRWIDTH-1 to 0; branch targets are computed modulo 2^IADDRWIDTH.
REQ-024 SHALL give a taken branch priority over fetch advance when both occur in the same cycle; a branch in S2 while ivalid=0 redirects pc immediately.

Reset
REQ-025 SHALL, while rst is high, hold pc=0, ir_valid=0, ireq=0, wb_valid=0, wb_addr=0, wb_data=0, and all registers=0.
REQ-026 SHALL, in the first cycle after rst falls, drive ireq=1 with iaddr=0.
REQ-027 SHALL, if rst is asserted mid-stall or mid-extended-immediate, abandon the stall with no writeback.

Configuration
REQ-028 SHALL, when macro CPU_PIPE_EXTIMM_EN is defined, implement bmode 10/rb==0 per REQ-021.
REQ-029 SHALL, when CPU_PIPE_EXTIMM_EN is undefined, use operand B = 0 for bmode 10/rb==0, with no stall and no extra fetch.

Verification
REQ-030 SHALL cover: after reset, idata "add r1=r0+5" (0x0025), ivalid=1 -> next cycle wb_valid=1, wb_addr=1, wb_data=5.
REQ-031 SHALL cover: r1=5, then "sub r2=r1-(-1)" -> wb_data=6; DWIDTH=16 add 0xFFFF+1 -> 0x0000.
REQ-032 SHALL cover: a branch at address 4 with r0==0, op 1100, offset 3 -> iaddr=8 next cycle, one bubble, and the word at 5 never retires.
REQ-033 SHALL cover: ivalid held low for 3 cycles -> iaddr constant, no wb_valid, then normal retire.
REQ-034 SHALL cover: with CPU_PIPE_EXTIMM_EN, "or r3=r0|ext" followed by word 0x8001 -> wb_data=0xFFFF8001 (DWIDTH=32), and the next instruction is fetched from pc+2.
REQ-035 SHALL cover: rst asserted during the extended-immediate stall -> no wb_valid; restart fetches from 0.
